alu_muldiv: RTL
===============

Name: alu_muldiv

Overview:
- Parametrised iterative multiply/divide unit for the RV32M extension; successor to the single-cycle combinational ALU.
- Sits beside the ALU in the execute stage and is selected for funct7=0000001 R-type ops.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle.
- Valid/ready handshake on both sides; the pipeline stalls while the unit is busy.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and >=8.
- OPCODE_LENGTH, 3, width of Operation; encoding equals RISC-V funct3.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; returns to IDLE, result discarded.
- in_valid  in  1  operands and Operation valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- SrcA  in  DATA_WIDTH  rs1 (multiplicand / dividend).
- SrcB  in  DATA_WIDTH  rs2 (multiplier / divisor).
- Operation  in  OPCODE_LENGTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- out_valid  out  1  ALUResult valid.
- out_ready  in  1  consumer accepts the result.
- ALUResult  out  DATA_WIDTH  result; held stable while out_valid && !out_ready.
- busy  out  1  high in CALC or FIX.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, ALUResult=0, busy=0, counter=0, internal registers 0.
- FSM states are IDLE, CALC, FIX, DONE.
- IDLE:
  - Accept when in_valid && in_ready.
  - Latch the op and operand magnitudes: signed ops take the two's-complement absolute value; SrcB is signed for MULH only, and SrcA is signed for MULH and MULHSU.
  - Latch the result sign: XOR of operand signs for MUL/MULH/MULHSU/DIV; dividend sign for REM.
  - Go to CALC with counter=DATA_WIDTH.
  - Special cases bypass CALC and go straight to FIX:
    - divisor==0: quotient = all ones, remainder = SrcA.
    - signed overflow (SrcA = 1 followed by zeros, SrcB = all ones, DIV/REM): quotient = SrcA, remainder = 0.
    - Neither case receives sign correction.
- CALC, one iteration per cycle, counter decrements, leave when counter reaches 1 after its update:
  - MUL*: 2*DATA_WIDTH product accumulator, add-and-shift.
  - DIV*: restoring divide; remainder shift-left, trial subtract, quotient bit set if non-negative.
- FIX (1 cycle):
  - Apply sign correction (two's-complement negate if the sign flag is set).
  - Select the result: MUL takes low half, MULH* high half, DIV* quotient, REM* remainder.
  - Register ALUResult, go to DONE.
- DONE: out_valid=1. On out_ready, go to IDLE next cycle with out_valid=0. No back-to-back accept in the DONE cycle.
- Latency from the accept edge to out_valid:
  - Normal ops: DATA_WIDTH+2 cycles.
  - Special cases: 2 cycles.
- flush:
  - Highest priority after reset; in any state, next state is IDLE and out_valid=0.
  - ALUResult keeps its last value.
  - flush && in_valid in IDLE: not accepted.
- in_valid while busy is ignored; the upstream stage must hold its request.
- Width rules: all arithmetic is unsigned on magnitudes; MULHSU treats SrcB as unsigned even with MSB=1; no result saturation.

Optional Feature:
- Macro: ALU_MULDIV_FAST_MUL_EN.
- Defined:
  - MUL* ops use a single combinational 2*DATA_WIDTH signed multiply (operands sign/zero-extended by one bit).
  - Path is IDLE->FIX->DONE, giving out_valid 2 cycles after accept.
  - Division is unchanged.
- Undefined: iterative multiply as above; no hardware multiplier is inferred.

Decomposition:
- Package alu_muldiv_pkg:
  - typedef enum of the 8 M-ext opcodes (muldiv_op_e).
  - typedef enum state_e {IDLE, CALC, FIX, DONE}.
  - Function abs_val.
  - Constants for the default DATA_WIDTH and the DIV_BY_ZERO quotient pattern.
- One sub-module, muldiv_datapath: accumulator/remainder registers and per-iteration add/subtract step.
- The FSM, handshake and sign fix stay in alu_muldiv.

Test Plan:
- MUL 7 × -3 (W=32), out_ready=1 → out_valid at cycle 34 after accept, ALUResult=0xFFFFFFEB.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULH same operands → 0x00000000; MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- DIV -7 / 2 → 0xFFFFFFFD; REM -7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF at cycle 2; REMU 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Backpressure and reset: hold out_ready=0 for 10 cycles in DONE → ALUResult stable, in_ready=0; deassert rst_n mid-CALC → all outputs reset immediately, asynchronously.
- flush in CALC cycle 5 → IDLE next cycle, out_valid never rises; a following DIVU 9/3 returns 3.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// alu_muldiv_pkg: shared types and helpers for the RV32M multiply/divide unit.
package alu_muldiv_pkg;

    localparam int DEF_DATA_WIDTH = 32;

    // Helpers work on a fixed 64-bit container, so DATA_WIDTH is limited to 32
    // (the full product must fit).
    localparam int MAX_WIDTH = 64;

    // Quotient returned for a divide by zero (truncated to DATA_WIDTH at use).
    localparam logic [MAX_WIDTH-1:0] DIV_BY_ZERO_Q = '1;

    // Encoding equals RISC-V funct3.
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    // Two's-complement negate when neg is set; callers zero-extend the input
    // and truncate the result back to their own width.
    function automatic logic [MAX_WIDTH-1:0] abs_val(input logic [MAX_WIDTH-1:0] v,
                                                     input logic                 neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/alu_muldiv_datapath.sv
// muldiv_datapath: shared 2*DATA_WIDTH accumulator and operand register.
// Multiply: acc = {partial_hi, multiplier}, add-and-shift right.
// Divide:   acc = {remainder, dividend/quotient}, restoring shift-left.
module muldiv_datapath
    import alu_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic                      step,
    input  logic                      is_div,
    input  logic [2*DATA_WIDTH-1:0]   init_acc,
    input  logic [DATA_WIDTH-1:0]     init_opnd,
    output logic [2*DATA_WIDTH-1:0]   acc
);

    localparam int W = DATA_WIDTH;

    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   opnd_q, opnd_d;
    logic [W:0]     trial;
    logic [W:0]     sum;

    // One iteration: trial subtract for divide, conditional add for multiply.
    always_comb begin
        trial  = acc_q[2*W-1:W-1] - {1'b0, opnd_q};
        sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
        acc_d  = acc_q;
        opnd_d = opnd_q;
        if (load) begin
            acc_d  = init_acc;
            opnd_d = init_opnd;
        end else if (step) begin
            if (is_div) begin
                if (!trial[W]) begin
                    acc_d = {trial[W-1:0], acc_q[W-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*W-2:0], 1'b0};
                end
            end else if (acc_q[0]) begin
                acc_d = {sum, acc_q[W-1:1]};
            end else begin
                acc_d = {1'b0, acc_q[2*W-1:1]};
            end
        end
    end

    // Accumulator and operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit with valid/ready handshake.
// Optional feature macro ALU_MULDIV_FAST_MUL_EN: MUL* ops use one combinational
// signed multiply and skip CALC; division stays iterative.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high
// CALC  | one multiply/divide iteration per cycle, counter counts down
// FIX   | sign correction, result select, ALUResult registered
// DONE  | out_valid high until out_ready
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     busy
);

    localparam int W         = DATA_WIDTH;
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    muldiv_op_e           op_q, op_d;
    logic                 sign_q, sign_d;
    logic [W-1:0]         result_q, result_d;

    muldiv_op_e     op_in;
    logic           neg_a, neg_b, div_zero, div_ovf, hi_sel;
    logic [W-1:0]   a_mag, b_mag, sel, res;
    logic [2*W-1:0] acc_fix;

    logic           dp_load, dp_step;
    logic [2*W-1:0] dp_init_acc, dp_acc;
    logic [W-1:0]   dp_init_opnd;

    // Operand decode: signedness, magnitudes and the two divide special cases.
    always_comb begin
        op_in    = muldiv_op_e'(Operation);
        neg_a    = (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && SrcA[W-1];
        neg_b    = (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && SrcB[W-1];
        a_mag    = W'(abs_val(MAX_WIDTH'(SrcA), neg_a));
        b_mag    = W'(abs_val(MAX_WIDTH'(SrcB), neg_b));
        div_zero = op_in[2] && (SrcB == '0);
        div_ovf  = (op_in inside {OP_DIV, OP_REM}) &&
                   (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
    end

`ifdef ALU_MULDIV_FAST_MUL_EN
    logic signed [2*W-1:0] fast_prod;

    // Single-cycle product of the one-bit sign/zero-extended operands.
    always_comb begin
        fast_prod = $signed((2*W)'($signed({neg_a, SrcA}))) *
                    $signed((2*W)'($signed({neg_b, SrcB})));
    end
`endif

    // Product sign fix works on the full width so MULH* see the right high half;
    // quotient and remainder are negated independently after selection.
    always_comb begin
        hi_sel  = op_q inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
        acc_fix = (2*W)'(abs_val(MAX_WIDTH'(dp_acc), sign_q && !op_q[2]));
        sel     = hi_sel ? acc_fix[2*W-1:W] : acc_fix[W-1:0];
        res     = W'(abs_val(MAX_WIDTH'(sel), sign_q && op_q[2]));
    end

    // Next-state and datapath control; flush overrides everything but reset.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        sign_d       = sign_q;
        result_d     = result_q;
        dp_load      = 1'b0;
        dp_step      = 1'b0;
        dp_init_acc  = '0;
        dp_init_opnd = '0;
        unique case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    op_d    = op_in;
                    dp_load = 1'b1;
                    sign_d  = (op_in inside {OP_REM, OP_REMU}) ? neg_a : (neg_a ^ neg_b);
                    if (div_zero) begin
                        sign_d      = 1'b0;
                        dp_init_acc = {SrcA, W'(DIV_BY_ZERO_Q)};
                        state_d     = FIX;
                    end else if (div_ovf) begin
                        sign_d      = 1'b0;
                        dp_init_acc = {{W{1'b0}}, SrcA};
                        state_d     = FIX;
`ifdef ALU_MULDIV_FAST_MUL_EN
                    end else if (!op_in[2]) begin
                        sign_d      = 1'b0;
                        dp_init_acc = fast_prod;
                        state_d     = FIX;
`endif
                    end else if (op_in[2]) begin
                        dp_init_acc  = {{W{1'b0}}, a_mag};
                        dp_init_opnd = b_mag;
                        cnt_d        = CNT_WIDTH'(W);
                        state_d      = CALC;
                    end else begin
                        dp_init_acc  = {{W{1'b0}}, b_mag};
                        dp_init_opnd = a_mag;
                        cnt_d        = CNT_WIDTH'(W);
                        state_d      = CALC;
                    end
                end
            end
            CALC: begin
                dp_step = 1'b1;
                cnt_d   = cnt_q - CNT_WIDTH'(1);
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = res;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            dp_step = 1'b0;
        end
    end

    // FSM and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            sign_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            result_q <= result_d;
        end
    end

    muldiv_datapath #(
        .DATA_WIDTH (W)
    ) u_datapath (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (dp_load),
        .step      (dp_step),
        .is_div    (op_q[2]),
        .init_acc  (dp_init_acc),
        .init_opnd (dp_init_opnd),
        .acc       (dp_acc)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == CALC) || (state_q == FIX);
    assign ALUResult = result_q;

endmodule
